// File: rtl/sc_unit.sv
// sc_unit: store-conditional resolution for the MEM stage.
// Holds the LL reservation, resolves SC success/failure against the
// (bypassed) LLbit, and performs the conditional bus write with req/ack.
module sc_unit #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned RES_LSB = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              ll_valid,
    input  logic [ADDR_W-1:0] ll_addr,
    input  logic              sc_valid,
    input  logic [ADDR_W-1:0] sc_addr,
    input  logic [DATA_W-1:0] sc_wdata,
    input  logic              llbit_i,
    input  logic              wb_llbit_we,
    input  logic              wb_llbit_value,
    input  logic              snoop_we,
    input  logic [ADDR_W-1:0] snoop_addr,
    input  logic              mem_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_sel,
    output logic              stall_req,
    output logic              sc_done,
    output logic [DATA_W-1:0] sc_result,
    output logic              llbit_we_o,
    output logic              llbit_o,
    output logic              res_valid_o
);

    localparam int unsigned RA_W = ADDR_W - RES_LSB;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                res_valid_q, res_valid_d;
    logic [RA_W-1:0]     res_addr_q, res_addr_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                mem_req_q, mem_req_d;

    logic                eff_llbit;
    logic                res_match;
    logic                snoop_hit;
    logic                stall_c;
    logic                done_c;
    logic                ok_c;
    logic                llwe_c;
    logic                llval_c;

    // Granule offset bits never take part in reservation compares
    logic                unused_low_bits;
    assign unused_low_bits = ^{ll_addr[RES_LSB-1:0], snoop_addr[RES_LSB-1:0]};

    // LLbit as seen by this SC, with WB-stage bypass, and reservation hits
    always_comb begin
        eff_llbit = wb_llbit_we ? wb_llbit_value : llbit_i;
        res_match = res_valid_q && (res_addr_q == sc_addr[ADDR_W-1:RES_LSB]);
        snoop_hit = snoop_we && (snoop_addr[ADDR_W-1:RES_LSB] == res_addr_q);
    end

    // Next-state, reservation update and same-cycle responses
    always_comb begin
        state_d     = state_q;
        res_valid_d = res_valid_q & ~snoop_hit;
        res_addr_d  = res_addr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        stall_c     = 1'b0;
        done_c      = 1'b0;
        ok_c        = 1'b0;
        llwe_c      = 1'b0;
        llval_c     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (flush) begin
                    res_valid_d = 1'b0;
                end else if (sc_valid) begin
                    if (eff_llbit && res_match && !snoop_hit) begin
                        state_d     = S_WAIT;
                        mem_addr_d  = sc_addr;
                        mem_wdata_d = sc_wdata;
                        stall_c     = 1'b1;
                    end else begin
                        done_c      = 1'b1;
                        res_valid_d = 1'b0;
                    end
                end else if (ll_valid) begin
                    res_addr_d  = ll_addr[ADDR_W-1:RES_LSB];
                    res_valid_d = 1'b1;
                    llwe_c      = 1'b1;
                    llval_c     = 1'b1;
                end
            end
            S_WAIT: begin
                if (flush) begin
                    // Bus write cannot be abandoned; finish it silently
                    res_valid_d = 1'b0;
                    state_d     = mem_ack ? S_IDLE : S_DRAIN;
                end else if (mem_ack) begin
                    done_c      = 1'b1;
                    ok_c        = 1'b1;
                    llwe_c      = 1'b1;
                    res_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end else begin
                    stall_c = 1'b1;
                end
            end
            S_DRAIN: begin
                if (mem_ack) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        mem_req_d = (state_d != S_IDLE);
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            res_valid_q <= 1'b0;
            res_addr_q  <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_req_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            res_valid_q <= res_valid_d;
            res_addr_q  <= res_addr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_req_q   <= mem_req_d;
        end
    end

    // Output drive; same-cycle responses are held low while in reset
    always_comb begin
        mem_req     = mem_req_q;
        mem_we      = mem_req_q;
        mem_sel     = mem_req_q ? 4'b1111 : 4'b0000;
        mem_addr    = mem_addr_q;
        mem_wdata   = mem_wdata_q;
        res_valid_o = res_valid_q;
        stall_req   = stall_c & ~rst;
        sc_done     = done_c & ~rst;
        sc_result   = DATA_W'(ok_c & ~rst);
        llbit_we_o  = llwe_c & ~rst;
        llbit_o     = llval_c & ~rst;
    end

endmodule

// File: tb/tb_sc_unit.sv
// Testbench for sc_unit: directed scenarios followed by random traffic,
// all checked against a transaction-level model of LL/SC semantics.
module tb_sc_unit;

    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned LSB = 2;

    logic          clk = 1'b0;
    logic          rst, flush, ll_valid, sc_valid, llbit_i;
    logic          wb_llbit_we, wb_llbit_value, snoop_we, mem_ack;
    logic [AW-1:0] ll_addr, sc_addr, snoop_addr;
    logic [DW-1:0] sc_wdata;
    logic          mem_req, mem_we, stall_req, sc_done, llbit_we_o, llbit_o, res_valid_o;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, sc_result;
    logic [3:0]    mem_sel;

    int checks = 0;
    int errors = 0;

    // Model: reservation, and the bus transaction in flight (0 none, 1 SC owns it, 2 orphaned)
    bit            m_rv;
    logic [AW-1:0] m_ra;
    int            m_bus;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    bit            n_rv;
    logic [AW-1:0] n_ra;
    int            n_bus;
    logic [AW-1:0] n_addr;
    logic [DW-1:0] n_data;

    always #5 clk = ~clk;

    sc_unit #(.ADDR_W(AW), .DATA_W(DW), .RES_LSB(LSB)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .ll_valid(ll_valid), .ll_addr(ll_addr),
        .sc_valid(sc_valid), .sc_addr(sc_addr), .sc_wdata(sc_wdata),
        .llbit_i(llbit_i), .wb_llbit_we(wb_llbit_we), .wb_llbit_value(wb_llbit_value),
        .snoop_we(snoop_we), .snoop_addr(snoop_addr), .mem_ack(mem_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_sel(mem_sel), .stall_req(stall_req), .sc_done(sc_done), .sc_result(sc_result),
        .llbit_we_o(llbit_we_o), .llbit_o(llbit_o), .res_valid_o(res_valid_o)
    );

    function automatic bit same_granule(input logic [AW-1:0] a, input logic [AW-1:0] b);
        return (a >> LSB) == (b >> LSB);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic idle_in();
        rst = 1'b0; flush = 1'b0; ll_valid = 1'b0; sc_valid = 1'b0; llbit_i = 1'b1;
        wb_llbit_we = 1'b0; wb_llbit_value = 1'b0; snoop_we = 1'b0; mem_ack = 1'b0;
        ll_addr = '0; sc_addr = '0; sc_wdata = '0; snoop_addr = '0;
    endtask

    // Let inputs settle, predict this cycle's outputs and next state, compare all outputs
    task automatic settle();
        bit e_stall, e_done, e_ok, e_lwe, e_lval, eff, snoop_hit;
        #1;
        e_stall = 0; e_done = 0; e_ok = 0; e_lwe = 0; e_lval = 0;
        n_rv = m_rv; n_ra = m_ra; n_bus = m_bus; n_addr = m_addr; n_data = m_data;
        eff       = wb_llbit_we ? wb_llbit_value : llbit_i;
        snoop_hit = snoop_we && same_granule(snoop_addr, m_ra);
        if (snoop_hit) n_rv = 0;
        if (rst) begin
            n_rv = 0; n_ra = '0; n_bus = 0; n_addr = '0; n_data = '0;
        end else if (m_bus == 0) begin
            if (flush) n_rv = 0;
            else if (sc_valid) begin
                if (eff && m_rv && same_granule(sc_addr, m_ra) && !snoop_hit) begin
                    n_bus = 1; n_addr = sc_addr; n_data = sc_wdata; e_stall = 1;
                end else begin
                    e_done = 1; n_rv = 0;
                end
            end else if (ll_valid) begin
                n_ra = ll_addr; n_rv = 1; e_lwe = 1; e_lval = 1;
            end
        end else if (m_bus == 1) begin
            if (flush) begin
                n_rv = 0; n_bus = mem_ack ? 0 : 2;
            end else if (mem_ack) begin
                e_done = 1; e_ok = 1; e_lwe = 1; n_rv = 0; n_bus = 0;
            end else e_stall = 1;
        end else begin
            if (mem_ack) n_bus = 0;
        end
        chk("mem_req",     32'(mem_req),     32'(m_bus != 0));
        chk("mem_we",      32'(mem_we),      32'(m_bus != 0));
        chk("mem_sel",     32'(mem_sel),     (m_bus != 0) ? 32'hF : 32'h0);
        chk("mem_addr",    mem_addr,         m_addr);
        chk("mem_wdata",   mem_wdata,        m_data);
        chk("res_valid_o", 32'(res_valid_o), 32'(m_rv));
        chk("stall_req",   32'(stall_req),   32'(e_stall));
        chk("sc_done",     32'(sc_done),     32'(e_done));
        chk("sc_result",   sc_result,        32'(e_ok));
        chk("llbit_we_o",  32'(llbit_we_o),  32'(e_lwe));
        chk("llbit_o",     32'(llbit_o),     32'(e_lval));
    endtask

    task automatic tick();
        @(posedge clk);
        m_rv = n_rv; m_ra = n_ra; m_bus = n_bus; m_addr = n_addr; m_data = n_data;
        #1;
    endtask

    task automatic step();
        settle();
        tick();
    endtask

    initial begin
        idle_in();
        rst = 1'b1;
        @(posedge clk); #1;
        m_rv = 0; m_ra = '0; m_bus = 0; m_addr = '0; m_data = '0;
        step();                       // reset state checked by the model
        idle_in();
        step();

        // Success path with a 3-cycle ack delay
        ll_valid = 1; ll_addr = 32'h100; llbit_i = 0;
        settle(); chk("t1_ll_we", 32'(llbit_we_o), 32'd1); tick();
        idle_in(); step(); step();
        sc_valid = 1; sc_addr = 32'h100; sc_wdata = 32'hDEAD;
        settle(); chk("t1_stall_n", 32'(stall_req), 32'd1); tick();
        idle_in();
        settle(); chk("t1_req_n1", 32'(mem_req), 32'd1); chk("t1_data", mem_wdata, 32'hDEAD); tick();
        settle(); chk("t1_stall_n2", 32'(stall_req), 32'd1); tick();
        mem_ack = 1;
        settle();
        chk("t1_done", 32'(sc_done), 32'd1); chk("t1_result", sc_result, 32'd1);
        chk("t1_llwe", 32'(llbit_we_o), 32'd1); chk("t1_llo", 32'(llbit_o), 32'd0);
        chk("t1_stall_m", 32'(stall_req), 32'd0);
        tick();
        idle_in();
        settle(); chk("t1_req_off", 32'(mem_req), 32'd0); tick();

        // Mismatched granule fails immediately
        ll_valid = 1; ll_addr = 32'h100; step();
        idle_in(); sc_valid = 1; sc_addr = 32'h104;
        settle(); chk("t2_done", 32'(sc_done), 32'd1); chk("t2_result", sc_result, 32'd0); tick();
        idle_in();
        settle(); chk("t2_noreq", 32'(mem_req), 32'd0); chk("t2_rv", 32'(res_valid_o), 32'd0); tick();

        // Same-cycle snoop kills the SC
        ll_valid = 1; ll_addr = 32'h200; step();
        idle_in(); sc_valid = 1; sc_addr = 32'h200; snoop_we = 1; snoop_addr = 32'h200;
        settle(); chk("t3_done", 32'(sc_done), 32'd1); chk("t3_result", sc_result, 32'd0); tick();
        idle_in();
        settle(); chk("t3_noreq", 32'(mem_req), 32'd0); tick();

        // Flush while the write is on the bus drains it without a result
        ll_valid = 1; ll_addr = 32'h300; step();
        idle_in(); sc_valid = 1; sc_addr = 32'h300; sc_wdata = 32'h3333; step();
        idle_in(); flush = 1;
        settle(); chk("t4_stall", 32'(stall_req), 32'd0); chk("t4_nodone", 32'(sc_done), 32'd0); tick();
        idle_in();
        settle(); chk("t4_req_held", 32'(mem_req), 32'd1); tick();
        mem_ack = 1;
        settle(); chk("t4_nodone_ack", 32'(sc_done), 32'd0); chk("t4_nollwe", 32'(llbit_we_o), 32'd0); tick();
        idle_in();
        settle(); chk("t4_idle", 32'(mem_req), 32'd0); tick();

        // WB bypass supplies the LLbit
        ll_valid = 1; ll_addr = 32'h400; step();
        idle_in(); sc_valid = 1; sc_addr = 32'h402; sc_wdata = 32'h4444;
        llbit_i = 0; wb_llbit_we = 1; wb_llbit_value = 1;
        settle(); chk("t5_stall", 32'(stall_req), 32'd1); tick();
        idle_in(); mem_ack = 1;
        settle(); chk("t5_result", sc_result, 32'd1); tick();
        idle_in(); step();

        // Reset in WAIT
        ll_valid = 1; ll_addr = 32'h500; step();
        idle_in(); sc_valid = 1; sc_addr = 32'h500; step();
        idle_in(); rst = 1; step();
        idle_in();
        settle(); chk("t6_req", 32'(mem_req), 32'd0); chk("t6_rv", 32'(res_valid_o), 32'd0); tick();

        // Random traffic over a small address pool so reservations often hit
        for (int i = 0; i < 800; i++) begin
            logic [AW-1:0] pool [4];
            pool[0] = 32'h100; pool[1] = 32'h104; pool[2] = 32'h200; pool[3] = 32'h203;
            idle_in();
            rst            = ($urandom_range(0, 99) < 1);
            flush          = ($urandom_range(0, 99) < 5);
            ll_valid       = ($urandom_range(0, 99) < 30);
            ll_addr        = pool[$urandom_range(0, 3)];
            sc_valid       = ($urandom_range(0, 99) < 30);
            sc_addr        = pool[$urandom_range(0, 3)];
            sc_wdata       = $urandom;
            llbit_i        = ($urandom_range(0, 99) < 80);
            wb_llbit_we    = ($urandom_range(0, 99) < 15);
            wb_llbit_value = 1'($urandom_range(0, 1));
            snoop_we       = !ll_valid && ($urandom_range(0, 99) < 10);
            snoop_addr     = pool[$urandom_range(0, 3)];
            mem_ack        = ($urandom_range(0, 99) < 40);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
